// File: rtl/br_write_buffer.sv
// Write-side front end for the 32x32 register bank: FIFO of pending writebacks, drained one per
// cycle into the bank write port, with newest-value forwarding to two read ports. Option: ZERO_REG_EN.
module br_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_adrs,
  input  logic [DW-1:0]              in_data,
  input  logic                       drain_stall,
  output logic                       RegEn,
  output logic [AW-1:0]              adrsWrite,
  output logic [DW-1:0]              write,
  input  logic [AW-1:0]              qA_adrs,
  input  logic [AW-1:0]              qB_adrs,
  output logic                       fwdA_hit,
  output logic [DW-1:0]              fwdA_data,
  output logic                       fwdB_hit,
  output logic [DW-1:0]              fwdB_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] mem_adrs [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign in_ready = !rst && !full;

`ifdef ZERO_REG_EN
  // Register 0 is hard-wired zero: accept the handshake but drop the write.
  assign push = in_valid && in_ready && (in_adrs != '0);
`else
  assign push = in_valid && in_ready;
`endif

  assign RegEn     = !rst && !empty && !drain_stall;
  assign pop       = RegEn;
  assign adrsWrite = empty ? '0 : mem_adrs[rd_ptr];
  assign write     = empty ? '0 : mem_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_adrs[wr_ptr] <= in_adrs;
      mem_data[wr_ptr] <= in_data;
    end
  end

  // Walk oldest to newest so the most recently pushed match overrides earlier ones.
  always_comb begin
    logic [PW-1:0] idx;
    fwdA_hit  = 1'b0;
    fwdA_data = '0;
    fwdB_hit  = 1'b0;
    fwdB_data = '0;
    idx       = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (CW'(k) < count) begin
        if (mem_adrs[idx] == qA_adrs) begin
          fwdA_hit  = 1'b1;
          fwdA_data = mem_data[idx];
        end
        if (mem_adrs[idx] == qB_adrs) begin
          fwdB_hit  = 1'b1;
          fwdB_data = mem_data[idx];
        end
      end
    end
`ifdef ZERO_REG_EN
    if (qA_adrs == '0) begin
      fwdA_hit  = 1'b0;
      fwdA_data = '0;
    end
    if (qB_adrs == '0) begin
      fwdB_hit  = 1'b0;
      fwdB_data = '0;
    end
`endif
    if (rst) begin
      fwdA_hit  = 1'b0;
      fwdA_data = '0;
      fwdB_hit  = 1'b0;
      fwdB_data = '0;
    end
  end

endmodule

// File: tb/tb_br_write_buffer.sv
// Bench for br_write_buffer: queue-based reference model checked every cycle plus directed checks.
module tb_br_write_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  typedef struct packed {
    logic [AW-1:0] adrs;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_adrs;
  logic [DW-1:0] in_data;
  logic          drain_stall;
  logic          RegEn;
  logic [AW-1:0] adrsWrite;
  logic [DW-1:0] write;
  logic [AW-1:0] qA_adrs;
  logic [AW-1:0] qB_adrs;
  logic          fwdA_hit;
  logic [DW-1:0] fwdA_data;
  logic          fwdB_hit;
  logic [DW-1:0] fwdB_data;
  logic [2:0]    count;

  int  n_vec;
  int  n_err;
  int  n_bank;
  wr_t sb[$];

  br_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_adrs(in_adrs), .in_data(in_data), .drain_stall(drain_stall),
    .RegEn(RegEn), .adrsWrite(adrsWrite), .write(write),
    .qA_adrs(qA_adrs), .qB_adrs(qB_adrs),
    .fwdA_hit(fwdA_hit), .fwdA_data(fwdA_data),
    .fwdB_hit(fwdB_hit), .fwdB_data(fwdB_data), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW:0] model_fwd(input logic [AW-1:0] q);
    logic [DW:0] r;
    r = '0;
`ifdef ZERO_REG_EN
    if (q == '0) return r;
`endif
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].adrs == q) begin
        r = {1'b1, sb[i].data};
        break;
      end
    end
    return r;
  endfunction

  // Reference model: inputs settle at posedge+1, so negedge sees what the next edge will act on.
  always @(negedge clk) begin
    logic        exp_ready;
    logic        exp_en;
    logic        zero_ok;
    logic [DW:0] fa;
    logic [DW:0] fb;
    exp_ready = !rst && (sb.size() != DEPTH);
    exp_en    = !rst && (sb.size() != 0) && !drain_stall;
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    if (!rst) check("count", 64'(count), 64'(sb.size()));
    check("RegEn", 64'(RegEn), 64'(exp_en));
    if (sb.size() == 0) begin
      check("empty_adrs", 64'(adrsWrite), 64'(0));
      check("empty_data", 64'(write), 64'(0));
    end else if (!rst) begin
      check("head_adrs", 64'(adrsWrite), 64'(sb[0].adrs));
      check("head_data", 64'(write), 64'(sb[0].data));
    end
    fa = rst ? '0 : model_fwd(qA_adrs);
    fb = rst ? '0 : model_fwd(qB_adrs);
    check("fwdA", 64'({fwdA_hit, fwdA_data}), 64'(fa));
    check("fwdB", 64'({fwdB_hit, fwdB_data}), 64'(fb));
    if (exp_en && RegEn) begin
      n_bank++;
      void'(sb.pop_front());
    end
`ifdef ZERO_REG_EN
    zero_ok = (in_adrs != '0);
`else
    zero_ok = 1'b1;
`endif
    if (rst) sb.delete();
    else if (in_valid && exp_ready && zero_ok) sb.push_back({in_adrs, in_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_adrs  = a;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain_all();
    drain_stall = 1'b0;
    for (int i = 0; i < 12 && count != 0; i++) tick();
    check("drained", 64'(count), 64'(0));
  endtask

  initial begin
    int bank0;
    n_vec = 0; n_err = 0; n_bank = 0;
    rst = 1'b1; in_valid = 1'b0; in_adrs = '0; in_data = '0;
    drain_stall = 1'b0; qA_adrs = '0; qB_adrs = '0;

    // 1: reset, then single push with one-cycle latency to the bank
    tick(); tick();
    check("rst_ready", 64'(in_ready), 64'(0));
    check("rst_regen", 64'(RegEn), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(in_ready), 64'(1));
    push_one(5'd5, 32'hA5A5_0001);
    check("t1_regen", 64'(RegEn), 64'(1));
    check("t1_adrs", 64'(adrsWrite), 64'(5));
    check("t1_data", 64'(write), 64'hA5A5_0001);
    check("t1_count1", 64'(count), 64'(1));
    tick();
    check("t1_count0", 64'(count), 64'(0));

    // 2: fill under stall, fifth push held, then ordered drain
    drain_stall = 1'b1;
    for (int i = 1; i <= 4; i++) push_one(AW'(i), DW'(32'h100 + i));
    check("t2_full_count", 64'(count), 64'(4));
    check("t2_full_ready", 64'(in_ready), 64'(0));
    push_one(5'd9, 32'h99);
    check("t2_held_count", 64'(count), 64'(4));
    drain_stall = 1'b0;
    bank0 = n_bank;
    repeat (4) tick();
    check("t2_writes", 64'(n_bank - bank0), 64'(4));
    check("t2_count", 64'(count), 64'(0));

    // 3: forwarding picks newest match
    drain_stall = 1'b1;
    push_one(5'd7, 32'd11);
    push_one(5'd7, 32'd22);
    qA_adrs = 5'd7; qB_adrs = 5'd8;
    #1;
    check("t3_hitA", 64'(fwdA_hit), 64'(1));
    check("t3_dataA", 64'(fwdA_data), 64'(22));
    check("t3_hitB", 64'(fwdB_hit), 64'(0));
    check("t3_dataB", 64'(fwdB_data), 64'(0));
    drain_all();

    // 4: concurrent push+pop at count=2, 20 writes through the wrapping FIFO
    drain_stall = 1'b1;
    bank0 = n_bank;
    push_one(5'd10, $urandom);
    push_one(5'd11, $urandom);
    drain_stall = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_adrs = AW'($urandom_range(1, 31));
      in_data = $urandom;
      qA_adrs = in_adrs;
      qB_adrs = AW'(i);
      tick();
      check("t4_count", 64'(count), 64'(2));
    end
    in_valid = 1'b0;
    drain_all();
    check("t4_writes", 64'(n_bank - bank0), 64'(22));

    // 5: reset mid-drain discards pending entries
    drain_stall = 1'b1;
    push_one(5'd20, 32'hDEAD_0001);
    push_one(5'd21, 32'hDEAD_0002);
    push_one(5'd22, 32'hDEAD_0003);
    check("t5_count3", 64'(count), 64'(3));
    bank0 = n_bank;
    drain_stall = 1'b0;
    rst = 1'b1;
    #1;
    check("t5_regen_rst", 64'(RegEn), 64'(0));
    tick();
    rst = 1'b0;
    #1;
    check("t5_count0", 64'(count), 64'(0));
    repeat (3) tick();
    check("t5_no_writes", 64'(n_bank - bank0), 64'(0));

    // 6: register 0 handling
    drain_stall = 1'b1;
    qA_adrs = '0;
    push_one(5'd0, 32'hFFFF_FFFF);
`ifdef ZERO_REG_EN
    check("t6_count", 64'(count), 64'(0));
    check("t6_hitA", 64'(fwdA_hit), 64'(0));
    drain_stall = 1'b0;
    #1;
    check("t6_regen", 64'(RegEn), 64'(0));
`else
    check("t6_count", 64'(count), 64'(1));
    check("t6_hitA", 64'(fwdA_hit), 64'(1));
    check("t6_dataA", 64'(fwdA_data), 64'hFFFF_FFFF);
    drain_stall = 1'b0;
    #1;
    check("t6_regen", 64'(RegEn), 64'(1));
    check("t6_adrs", 64'(adrsWrite), 64'(0));
`endif
    tick();
    check("t6_end_count", 64'(count), 64'(0));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
